layer_feeder: RTL and testbench
===============================

Name: layer_feeder

Overview:
Sequencer between two fully-connected layers. Captures one layer's parallel result bus (neurons x dataWidth) on its valid strobe, then streams the values one per cycle into the next layer's single-input neuron array.
- Optionally holds off the next frame until the downstream layer reports completion.
- Keeps a one-deep pending buffer so back-to-back frames are not lost.
- Sits between every hidden layer and the following layer, including the one feeding the output layer.

Parameters:
neurons, 10, values per frame (upstream layer width = downstream weightSize)
dataWidth, 16, bits per value
waitDone, 1, 1: after the last element, wait for next_done before streaming another frame; 0: stream frames back-to-back

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  one-cycle strobe; in_data holds a complete frame
in_data  in  neurons*dataWidth  frame; element i = in_data[i*dataWidth +: dataWidth]
next_done  in  1  one-cycle pulse from the downstream layer (its out_valid)
out_valid  out  1  out_data valid this cycle; downstream has no backpressure
out_data  out  dataWidth  current element
out_last  out  1  high with the final element (index neurons-1)
busy  out  1  high in STREAM or WAIT_DONE
overrun  out  1  sticky; set when a frame is dropped; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, idx=0, pending_full=0.
  - out_valid=0, out_last=0, out_data=0, busy=0, overrun=0.
  - Any in-flight frame is abandoned; no further out_valid until a new in_valid.
- States:
  - IDLE: nothing active.
  - STREAM: emitting elements.
  - WAIT_DONE: only when waitDone=1.
- IDLE + in_valid at edge N:
  - Frame is copied into the active register; state becomes STREAM.
  - Element 0 is presented registered at N+1 (out_valid=1), element k at N+1+k.
  - out_last=1 at N+neurons. Exactly neurons consecutive out_valid cycles, no gaps.
- STREAM, after emitting the last element:
  - waitDone=0 and pending_full=1: next edge moves pending into active, idx=0, stay STREAM. Element 0 of the new frame follows the last element of the old one with zero bubble.
  - waitDone=0 and pending_full=0: go to IDLE.
  - waitDone=1: go to WAIT_DONE.
- WAIT_DONE + next_done:
  - pending_full=1: load pending; element 0 appears in the next cycle.
  - pending_full=0: go to IDLE.
  - A next_done in the same cycle as the last element is also accepted and counts for that frame (skip WAIT_DONE).
- next_done outside WAIT_DONE / that last cycle: ignored.
- in_valid while busy:
  - pending_full=0: capture into pending, set pending_full.
  - pending_full=1: drop the new frame, set overrun. Pending keeps the older frame.
- in_valid in the same cycle the pending frame moves to active: new frame goes into pending (pending_full stays 1); no overrun.
- in_valid in IDLE with pending_full=0: direct to active, as above.
- idx counter width = $clog2(neurons) (min 1). No wrap past neurons-1; the counter resets to 0 on each frame load.
- out_data is a pure selection of stored bits; no arithmetic, no sign change.
- out_data holds the last value when out_valid=0 (not required zero); bench checks it only when out_valid=1.

Decomposition:
- Package nn_pkg: state enum typedef (IDLE, STREAM, WAIT_DONE) and an IDX_W localparam function of neurons.
- Sub-module frame_buffer: active+pending registers with load/promote/full/overrun logic.
- layer_feeder keeps the FSM, index counter and output mux.

Test Plan:
1. rst=1 three cycles, then in_valid with frame {0..9} = 16'h0010*(i+1), waitDone=1 -> out_valid at N+1..N+10 with data 0010,0020,...,00A0; out_last only at N+10; busy stays 1 until next_done.
2. Same frame, next_done pulsed at N+15 -> busy falls at N+16; a second in_valid at N+20 streams from N+21.
3. waitDone=0, in_valid at N and N+3 (frames A, B) -> A elements N+1..N+10, B elements N+11..N+20 with no gap; overrun=0.
4. waitDone=1, in_valid at N, N+2, N+4 -> third frame dropped, overrun=1 from N+5 and sticky; after next_done only the second frame streams.
5. rst asserted at N+4 mid-stream -> out_valid=0 at N+5, busy=0, overrun=0, pending cleared; no stale elements afterwards.
6. waitDone=1, next_done coincident with out_last and pending full -> pending element 0 at the very next cycle; no WAIT_DONE cycle.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the layer-to-layer feeder.
package nn_pkg;

    // Sequencer states. IDLE: no frame in flight. STREAM: one element per
    // cycle on out_data. WAIT_DONE: last element sent, waiting for the
    // downstream layer to finish before the next frame may start.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } feed_state_t;

    localparam int DEFAULT_NEURONS    = 10;
    localparam int DEFAULT_DATA_WIDTH = 16;

    // Width of an element index. A single-element frame still gets a 1-bit
    // counter so the index never has zero width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_w(DEFAULT_NEURONS);

endpackage

// File: rtl/frame_buffer.sv
// Two-deep frame storage: the active frame being streamed and one pending
// frame captured while the sequencer is busy. Drops a third frame and flags
// it as a sticky overrun.
module frame_buffer
    import nn_pkg::*;
#(
    parameter int neurons   = DEFAULT_NEURONS,
    parameter int dataWidth = DEFAULT_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [neurons*dataWidth-1:0]   in_data,
    input  logic                           load_direct,
    input  logic                           promote,
    output logic [neurons*dataWidth-1:0]   active,
    output logic                           pending_full,
    output logic                           overrun
);

    logic [neurons*dataWidth-1:0] pending;
    logic                         capture;

    // A frame that is not written straight into the active register is
    // offered to the pending slot instead.
    assign capture = in_valid & ~load_direct;

    // Active register: loaded straight from the input when starting from
    // rest, otherwise refilled from the pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
        end else if (load_direct) begin
            active <= in_data;
        end else if (promote) begin
            active <= pending;
        end
    end

    // Pending slot and overrun flag. When pending is promoted in the same
    // cycle a new frame arrives, the new frame takes the freed slot, so the
    // slot stays full and nothing is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
            overrun      <= 1'b0;
        end else if (promote) begin
            pending_full <= capture;
            if (capture) begin
                pending <= in_data;
            end
        end else if (capture) begin
            if (!pending_full) begin
                pending      <= in_data;
                pending_full <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_feeder.sv
// Serialises one fully-connected layer's parallel result into the next
// layer's single-input neuron array, one element per cycle.
//
// state     | meaning
// IDLE      | no frame in flight, outputs quiet
// STREAM    | presenting active[idx] with out_valid high
// WAIT_DONE | frame sent, holding off until next_done (waitDone=1 only)
module layer_feeder
    import nn_pkg::*;
#(
    parameter int neurons   = DEFAULT_NEURONS,
    parameter int dataWidth = DEFAULT_DATA_WIDTH,
    parameter bit waitDone  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [neurons*dataWidth-1:0] in_data,
    input  logic                         next_done,
    output logic                         out_valid,
    output logic [dataWidth-1:0]         out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int                 IDX_W    = idx_w(neurons);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(neurons - 1);

    feed_state_t                  state;
    feed_state_t                  state_next;
    logic [IDX_W-1:0]             idx;
    logic [neurons*dataWidth-1:0] active;
    logic                         pending_full;
    logic                         at_last;
    logic                         frame_end;
    logic                         load_direct;
    logic                         promote;

    frame_buffer #(
        .neurons   (neurons),
        .dataWidth (dataWidth)
    ) u_frame_buffer (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .load_direct  (load_direct),
        .promote      (promote),
        .active       (active),
        .pending_full (pending_full),
        .overrun      (overrun)
    );

    assign at_last = (state == STREAM) && (idx == LAST_IDX);

    // Next-state and frame-load decisions. frame_end marks the cycle in which
    // the current frame is finished and the next one may start; a next_done
    // arriving together with the last element already counts as finished.
    always_comb begin
        state_next  = state;
        frame_end   = 1'b0;
        load_direct = 1'b0;
        promote     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_direct = 1'b1;
                    state_next  = STREAM;
                end
            end
            STREAM: begin
                if (at_last) begin
                    frame_end = !waitDone || next_done;
                    if (!frame_end) begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                frame_end = next_done;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The older buffered frame always goes first. With nothing pending,
        // a frame arriving in this very cycle goes straight to active so it
        // is not stranded in the pending slot while the FSM drops to IDLE.
        if (frame_end) begin
            if (pending_full) begin
                promote    = 1'b1;
                state_next = STREAM;
            end else if (in_valid) begin
                load_direct = 1'b1;
                state_next  = STREAM;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Element index: restarts on every frame load and parks on the last
    // element rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (load_direct || promote) begin
            idx <= '0;
        end else if ((state == STREAM) && !at_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Outputs are decoded from registers only; out_data is a plain slice of
    // the active frame and holds its value outside STREAM.
    assign out_valid = (state == STREAM);
    assign out_last  = at_last;
    assign busy      = (state != IDLE);
    assign out_data  = active[idx*dataWidth +: dataWidth];

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder: one instance holds off on next_done, the
// other streams back-to-back. Both share stimulus.
module tb_layer_feeder;

    localparam int N  = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          next_done;
    logic [N*DW-1:0] in_data;

    logic          w_valid, w_last, w_busy, w_ovr;
    logic [DW-1:0] w_data;
    logic          n_valid, n_last, n_busy, n_ovr;
    logic [DW-1:0] n_data;

    int tests = 0;
    int fails = 0;

    logic [N*DW-1:0] frm_f1, frm_a, frm_b, frm_c;

    always #5 clk = ~clk;

    layer_feeder #(.neurons(N), .dataWidth(DW), .waitDone(1'b1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .next_done (next_done),
        .out_valid (w_valid),
        .out_data  (w_data),
        .out_last  (w_last),
        .busy      (w_busy),
        .overrun   (w_ovr)
    );

    layer_feeder #(.neurons(N), .dataWidth(DW), .waitDone(1'b0)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .next_done (next_done),
        .out_valid (n_valid),
        .out_data  (n_data),
        .out_last  (n_last),
        .busy      (n_busy),
        .overrun   (n_ovr)
    );

    function automatic logic [N*DW-1:0] ramp(input logic [15:0] base, input logic [15:0] stp);
        logic [N*DW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) begin
            f[i*DW +: DW] = base + stp * 16'(i);
        end
        return f;
    endfunction

    // Advance past one rising edge; inputs set afterwards are sampled at the
    // following edge, outputs read here are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        next_done = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        in_data = '0;
        frm_f1  = ramp(16'h0010, 16'h0010);
        frm_a   = ramp(16'h1000, 16'h0001);
        frm_b   = ramp(16'h2000, 16'h0001);
        frm_c   = ramp(16'h3000, 16'h0001);

        // 1: reset state, then one frame with waitDone=1
        do_reset();
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_last",  w_last,  0);
        chk("rst_w_busy",  w_busy,  0);
        chk("rst_w_ovr",   w_ovr,   0);
        chk("rst_w_data",  w_data,  0);
        chk("rst_n_valid", n_valid, 0);
        chk("rst_n_busy",  n_busy,  0);

        in_data  = frm_f1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t1_valid%0d", k), w_valid, 1);
            chk($sformatf("t1_data%0d", k),  w_data,  16'h0010 * (k + 1));
            chk($sformatf("t1_last%0d", k),  w_last,  (k == N - 1) ? 1 : 0);
            chk($sformatf("t1_busy%0d", k),  w_busy,  1);
            step();
        end
        chk("t1_after_valid", w_valid, 0);
        chk("t1_after_busy",  w_busy,  1);

        // 2: next_done at N+15, busy falls at N+16, restart at N+20
        repeat (3) step();
        chk("t2_busy_n14", w_busy, 1);
        step();
        next_done = 1'b1;
        step();
        next_done = 1'b0;
        chk("t2_busy_n16",  w_busy,  0);
        chk("t2_valid_n16", w_valid, 0);
        repeat (4) step();
        in_data  = frm_f1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_restart_valid", w_valid, 1);
        chk("t2_restart_data",  w_data,  16'h0010);

        // 3: waitDone=0, frames A at N and B at N+3 back-to-back
        do_reset();
        in_data  = frm_a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2 * N; k++) begin
            if (k == 2) begin
                in_data  = frm_b;
                in_valid = 1'b1;
            end
            chk($sformatf("t3_valid%0d", k), n_valid, 1);
            chk($sformatf("t3_data%0d", k),  n_data,
                (k < N) ? 16'h1000 + k : 16'h2000 + (k - N));
            chk($sformatf("t3_last%0d", k),  n_last,
                (k == N - 1 || k == 2 * N - 1) ? 1 : 0);
            chk($sformatf("t3_ovr%0d", k),   n_ovr, 0);
            step();
            in_valid = 1'b0;
        end
        chk("t3_end_valid", n_valid, 0);
        chk("t3_end_busy",  n_busy,  0);
        chk("t3_end_ovr",   n_ovr,   0);

        // 4: waitDone=1, frames at N, N+2, N+4: third dropped
        do_reset();
        in_data  = frm_a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 1) begin
                in_data  = frm_b;
                in_valid = 1'b1;
            end
            if (k == 3) begin
                in_data  = frm_c;
                in_valid = 1'b1;
            end
            chk($sformatf("t4a_data%0d", k), w_data, 16'h1000 + k);
            if (k == 3) chk("t4_ovr_before", w_ovr, 0);
            if (k >= 4) chk($sformatf("t4_ovr%0d", k), w_ovr, 1);
            step();
            in_valid = 1'b0;
        end
        chk("t4_wait_valid", w_valid, 0);
        chk("t4_wait_busy",  w_busy,  1);
        next_done = 1'b1;
        step();
        next_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t4b_valid%0d", k), w_valid, 1);
            chk($sformatf("t4b_data%0d", k),  w_data,  16'h2000 + k);
            step();
        end
        chk("t4_end_valid", w_valid, 0);
        chk("t4_end_ovr",   w_ovr,   1);
        next_done = 1'b1;
        step();
        next_done = 1'b0;
        chk("t4_idle_busy", w_busy, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_no_c%0d", k), w_valid, 0);
        end
        chk("t4_sticky_ovr", w_ovr, 1);

        // 5: reset at N+4 in mid-stream with a pending frame
        do_reset();
        in_data  = frm_a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_data0", w_data, 16'h1000);
        step();
        in_data  = frm_b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_data2", w_data, 16'h1002);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", w_valid, 0);
        chk("t5_busy",  w_busy,  0);
        chk("t5_ovr",   w_ovr,   0);
        chk("t5_n_valid", n_valid, 0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("t5_quiet_w%0d", k), w_valid, 0);
            chk($sformatf("t5_quiet_n%0d", k), n_valid, 0);
        end

        // 6: next_done together with out_last, pending full: zero bubble
        do_reset();
        in_data  = frm_a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 1) begin
                in_data  = frm_b;
                in_valid = 1'b1;
            end
            if (k == N - 1) next_done = 1'b1;
            chk($sformatf("t6a_data%0d", k), w_data, 16'h1000 + k);
            step();
            in_valid  = 1'b0;
            next_done = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t6b_valid%0d", k), w_valid, 1);
            chk($sformatf("t6b_data%0d", k),  w_data,  16'h2000 + k);
            step();
        end
        chk("t6_end_valid", w_valid, 0);
        chk("t6_end_busy",  w_busy,  1);
        chk("t6_end_ovr",   w_ovr,   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
